// File: rtl/bch_sigma_ibm_seq.sv
// Inversionless Berlekamp-Massey key-equation solver for BCH: one iteration per clock,
// full syndrome vector in, unnormalised error-locator polynomial out over valid/ack.

module bch_sigma_ibm_lane #(
    parameter int             M    = 4,
    parameter logic [M-1:0]   POLY = 4'h3
) (
    input  logic [M-1:0] sig,
    input  logic [M-1:0] syn_k,
    input  logic [M-1:0] b_prev,
    input  logic [M-1:0] gamma,
    input  logic [M-1:0] delta,
    output logic [M-1:0] dterm,
    output logic [M-1:0] sig_nxt
);

    // Standard-basis shift-and-add multiply, reduced by the low bits of the field polynomial.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ p;
            p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY : '0);
        end
        return acc;
    endfunction

    assign dterm   = gf_mul(sig, syn_k);
    assign sig_nxt = gf_mul(gamma, sig) ^ gf_mul(delta, b_prev);

endmodule

module bch_sigma_ibm_seq #(
    parameter int M = 4,
    parameter int T = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       ready,
    input  logic                       binary_mode,
    input  logic [M*2*T-1:0]           syn,
    output logic                       valid,
    input  logic                       ack,
    output logic [M*(T+1)-1:0]         sigma,
    output logic [$clog2(2*T+1)-1:0]   err_count,
    output logic                       fail
);

    localparam int NS = 2 * T;
    localparam int LW = $clog2(2 * T + 1);
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    function automatic int prim_poly(input int m);
        case (m)
            2:       prim_poly = 'h7;
            3:       prim_poly = 'hB;
            4:       prim_poly = 'h13;
            5:       prim_poly = 'h25;
            6:       prim_poly = 'h43;
            7:       prim_poly = 'h89;
            8:       prim_poly = 'h11D;
            9:       prim_poly = 'h211;
            10:      prim_poly = 'h409;
            11:      prim_poly = 'h805;
            12:      prim_poly = 'h1053;
            13:      prim_poly = 'h201B;
            14:      prim_poly = 'h4443;
            15:      prim_poly = 'h8003;
            16:      prim_poly = 'h1100B;
            default: prim_poly = 0;
        endcase
    endfunction

    localparam int                  PRIM     = prim_poly(M);
    localparam logic [M-1:0]        POLY     = PRIM[M-1:0];
    localparam logic [M*(T+1)-1:0]  ONE_POLY = {{(M*(T+1)-1){1'b0}}, 1'b1};
    localparam logic [M-1:0]        ONE      = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                 state, state_nxt;
    logic [NS-1:0][M-1:0]   syn_q;
    logic                   bin_q;
    logic [T:0][M-1:0]      sig_q, b_q, sigma_o;
    logic [T:0][M-1:0]      sig_nxt, b_nxt, dterm, syn_sel;
    logic [T:0][M-1:0]      sig_x1, b_x1, b_x2;
    logic [M-1:0]           gamma_q, delta;
    logic [LW-1:0]          l_q, r_q, l_nxt, r_nxt, l_fin, err_o;
    logic                   fail_o, upd, last;
    logic                   load, step_en, zero_syn;

    assign zero_syn  = (syn == '0);
    assign valid     = (state == DONE);
    assign sigma     = sigma_o;
    assign err_count = err_o;
    assign fail      = fail_o;

    // Multiplication by x (and x^2) is a coefficient shift; anything past degree T falls off.
    assign sig_x1 = {sig_q[T-1:0], {M{1'b0}}};
    assign b_x1   = {b_q[T-1:0], {M{1'b0}}};
    assign b_x2   = {b_x1[T-1:0], {M{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        load      = 1'b0;
        step_en   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = zero_syn ? DONE : ITER;
                end
            end
            ITER: begin
                step_en = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane j pairs sigma_j with S_(r+1-j); indices outside 1..2T contribute nothing.
    always_comb begin
        int k;
        k       = 0;
        syn_sel = '0;
        for (int j = 0; j <= T; j++) begin
            k = int'(r_q) + 1 - j;
            if (k >= 1 && k <= NS) syn_sel[j] = syn_q[IW'(k - 1)];
        end
    end

    for (genvar j = 0; j <= T; j++) begin : g_lane
        bch_sigma_ibm_lane #(
            .M    (M),
            .POLY (POLY)
        ) u_lane (
            .sig     (sig_q[j]),
            .syn_k   (syn_sel[j]),
            .b_prev  (b_x1[j]),
            .gamma   (gamma_q),
            .delta   (delta),
            .dterm   (dterm[j]),
            .sig_nxt (sig_nxt[j])
        );
    end

    always_comb begin
        delta = '0;
        for (int j = 0; j <= T; j++) delta = delta ^ dterm[j];
        upd   = (delta != '0) && (2 * int'(l_q) <= int'(r_q));
        // Binary codes skip the provably-zero odd discrepancies, hence x*sigma / x^2*B.
        if (bin_q) b_nxt = upd ? sig_x1 : b_x2;
        else       b_nxt = upd ? sig_q  : b_x1;
        l_nxt = LW'(int'(r_q) + 1 - int'(l_q));
        l_fin = upd ? l_nxt : l_q;
        r_nxt = r_q + (bin_q ? LW'(2) : LW'(1));
        last  = (int'(r_q) + (bin_q ? 2 : 1)) >= NS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syn_q   <= '0;
            bin_q   <= 1'b0;
            sig_q   <= '0;
            b_q     <= '0;
            gamma_q <= '0;
            l_q     <= '0;
            r_q     <= '0;
            sigma_o <= '0;
            err_o   <= '0;
            fail_o  <= 1'b0;
        end else if (load) begin
            syn_q   <= syn;
            bin_q   <= binary_mode;
            sig_q   <= ONE_POLY;
            b_q     <= ONE_POLY;
            gamma_q <= ONE;
            l_q     <= '0;
            r_q     <= '0;
            if (zero_syn) begin
                sigma_o <= ONE_POLY;
                err_o   <= '0;
                fail_o  <= 1'b0;
            end
        end else if (step_en) begin
            sig_q <= sig_nxt;
            b_q   <= b_nxt;
            r_q   <= r_nxt;
            if (upd) begin
                l_q     <= l_nxt;
                gamma_q <= delta;
            end
            if (last) begin
                sigma_o <= sig_nxt;
                err_o   <= l_fin;
                fail_o  <= (int'(l_fin) > T);
            end
        end
    end

endmodule

// File: tb/tb_bch_sigma_ibm_seq.sv
// Directed + random bench for bch_sigma_ibm_seq (M=4, T=3) against a log/antilog-table
// Berlekamp-Massey model working on integer coefficient arrays.

module tb_bch_sigma_ibm_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic        binary_mode;
    logic [23:0] syn;
    logic        valid;
    logic        ack;
    logic [15:0] sigma;
    logic [2:0]  err_count;
    logic        fail;

    int vectors     = 0;
    int miscompares = 0;
    int gexp[15];
    int glog[16];

    bch_sigma_ibm_seq #(.M(4), .T(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ready       (ready),
        .binary_mode (binary_mode),
        .syn         (syn),
        .valid       (valid),
        .ack         (ack),
        .sigma       (sigma),
        .err_count   (err_count),
        .fail        (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    function automatic int gdiv(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] - glog[b] + 15) % 15];
    endfunction

    function automatic int cf(input int a[4], input int i);
        return (i < 0 || i > 3) ? 0 : a[i];
    endfunction

    // sigma(x), B(x) as coefficient arrays; B is multiplied by x^shift each step.
    function automatic void model(input logic [23:0] sv, input bit bin,
                                  output logic [15:0] sig_o, output int l_o);
        int s[7];
        int sg[4], b[4], nsg[4], nb[4];
        int g, l, r, d, k, shift, step;
        s[0] = 0;
        for (int i = 1; i <= 6; i++) s[i] = int'(sv[(i-1)*4 +: 4]);
        sg = '{1, 0, 0, 0};
        b  = '{1, 0, 0, 0};
        g = 1; l = 0; r = 0;
        step = bin ? 2 : 1;
        for (int it = 0; it < 6 / step; it++) begin
            d = 0;
            for (int j = 0; j < 4; j++) begin
                k = r + 1 - j;
                if (k >= 1 && k <= 6) d = d ^ gmul(sg[j], s[k]);
            end
            for (int j = 0; j < 4; j++) nsg[j] = gmul(g, sg[j]) ^ gmul(d, cf(b, j - 1));
            if (d != 0 && 2 * l <= r) begin
                shift = step - 1;
                for (int j = 0; j < 4; j++) nb[j] = cf(sg, j - shift);
                l = r + 1 - l;
                g = d;
            end else begin
                for (int j = 0; j < 4; j++) nb[j] = cf(b, j - step);
            end
            sg = nsg;
            b  = nb;
            r  = r + step;
        end
        for (int j = 0; j < 4; j++) sig_o[j*4 +: 4] = 4'(sg[j]);
        l_o = l;
    endfunction

    task automatic run_job(input string tag, input logic [23:0] sv, input bit bin,
                           input bit interfere, output logic [15:0] es, output int el);
        int n, lat;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, ready, 1'b1);
        model(sv, bin, es, el);
        lat = (sv == '0) ? 0 : (bin ? 3 : 6);
        syn = sv;
        binary_mode = bin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        syn = 24'($urandom());
        binary_mode = ~bin;
        n = 0;
        while (!valid && n < 30) begin
            start = interfere && (n == 1);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_sigma"}, sigma, es);
        chk({tag, "_err"}, err_count, el);
        chk({tag, "_fail"}, fail, el > 3);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({tag, "_ack_ready"}, ready, 1'b1);
        chk({tag, "_ack_valid"}, valid, 1'b0);
    endtask

    initial begin
        logic [23:0] sv1, sv4, rs;
        logic [15:0] es;
        int          el, v;
        bit          rb;

        reset = 1'b1; start = 1'b0; ack = 1'b0; binary_mode = 1'b0; syn = '0;
        gexp[0] = 1;
        glog[0] = 0;
        glog[1] = 0;
        for (int i = 1; i < 15; i++) begin
            v = gexp[i-1] << 1;
            if ((v & 16) != 0) v = v ^ 'h13;
            gexp[i] = v;
            glog[v] = i;
        end
        sv1 = '0;
        sv4 = '0;
        for (int i = 1; i <= 6; i++) begin
            sv1[(i-1)*4 +: 4] = 4'(gexp[(5 * i) % 15]);
            v = 0;
            for (int p = 0; p < 4; p++) v = v ^ gexp[(p * i) % 15];
            sv4[(i-1)*4 +: 4] = 4'(v);
        end

        #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_sigma", sigma, 16'h0);
        chk("rst_err", err_count, 3'd0);
        chk("rst_fail", fail, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_job("zero", 24'h0, 1'b0, 1'b0, es, el);
        chk("zero_sigma_const", sigma, 16'h0001);
        do_ack("zero");

        run_job("one_bin", sv1, 1'b1, 1'b0, es, el);
        chk("one_bin_sigma_const", sigma, 16'h0017);
        chk("one_bin_err_const", err_count, 3'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold", {valid, sigma, err_count, fail}, {1'b1, es, 3'(el), 1'(el > 3)});
        end
        do_ack("one_bin");
        chk("keep_sigma", sigma, es);

        // Back-to-back: the next start goes out the same cycle ready returns.
        run_job("one_full", sv1, 1'b0, 1'b0, es, el);
        chk("one_full_norm1", gdiv(int'(sigma[7:4]), int'(sigma[3:0])), 6);
        chk("one_full_hi", sigma[15:8], 8'h0);
        chk("one_full_err_const", err_count, 3'd1);
        do_ack("one_full");

        run_job("four_bin", sv4, 1'b1, 1'b0, es, el);
        do_ack("four_bin");
        run_job("four_full", sv4, 1'b0, 1'b0, es, el);
        do_ack("four_full");

        // Only S6 nonzero: full mode jumps L to 2T, binary mode never sees it.
        run_job("s6_full", 24'h500000, 1'b0, 1'b0, es, el);
        chk("s6_full_err_const", err_count, 3'd6);
        chk("s6_full_fail_const", fail, 1'b1);
        chk("s6_full_sigma_const", sigma, 16'h0001);
        do_ack("s6_full");
        run_job("s6_bin", 24'h500000, 1'b1, 1'b0, es, el);
        chk("s6_bin_err_const", err_count, 3'd0);
        do_ack("s6_bin");

        run_job("busy_start_bin", sv1, 1'b1, 1'b1, es, el);
        do_ack("busy_start_bin");
        run_job("busy_start_full", sv4, 1'b0, 1'b1, es, el);
        do_ack("busy_start_full");

        syn = sv1;
        binary_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_sigma", sigma, 16'h0);
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_err", err_count, 3'd0);
        chk("mid_rst_fail", fail, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_job("after_rst", sv1, 1'b0, 1'b0, es, el);
        do_ack("after_rst");

        for (int t = 0; t < 24; t++) begin
            rs = 24'($urandom());
            if (t % 6 == 5) rs = rs & 24'h0F0F0F;
            rb = 1'($urandom_range(0, 1));
            run_job($sformatf("rnd%0d", t), rs, rb, 1'b0, es, el);
            do_ack($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
